// File: rtl/uvc_frame_sched.sv
// uvc_frame_sched: paces UVC iso frame starts to SOF slots and grants payloads per microframe
//   CLK_I/RST_I        clock, async active-high reset
//   SOF_I              SOF level; each rising edge is one microframe
//   ENABLE_I           streaming enabled
//   FIFO_EMPTY_I       endpoint FIFO empty
//   PKT_DONE_I         payload finished pulse
//   FRAME_END_I        last payload of frame pulse
//   FRAME_START_O      one-cycle frame start pulse
//   PKT_GRANT_O        packetizer may begin a payload
//   ACTIVE_O           frame in progress
//   FID_O              UVC frame-ID bit
//   UFRAME_O           microframe index 0..7
//   SOF_COUNT_O        11-bit USB frame number
//   PTS_O              timestamp latched at frame start
//   LATE_CNT_O         saturating count of slots missed while a frame was active
//   SKIP_CNT_O         saturating count of slots skipped on a non-empty FIFO
module uvc_frame_sched #(
    parameter int FRAME_INTERVAL  = 104,
    parameter int PKTS_PER_UFRAME = 1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        SOF_I,
    input  logic        ENABLE_I,
    input  logic        FIFO_EMPTY_I,
    input  logic        PKT_DONE_I,
    input  logic        FRAME_END_I,
    output logic        FRAME_START_O,
    output logic        PKT_GRANT_O,
    output logic        ACTIVE_O,
    output logic        FID_O,
    output logic [2:0]  UFRAME_O,
    output logic [10:0] SOF_COUNT_O,
    output logic [31:0] PTS_O,
    output logic [7:0]  LATE_CNT_O,
    output logic [7:0]  SKIP_CNT_O
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        s0_q, s1_q;
    logic [15:0] ival_q, ival_d;
    logic [1:0]  budget_q, budget_d;
    logic [31:0] pts_q;
    logic [2:0]  uframe_q;
    logic [10:0] sof_count_q;
    logic        start_q, active_q, fid_q;
    logic [31:0] pts_lat_q;
    logic [7:0]  late_q, skip_q;
    logic        sof_rise, slot, start, skip, late, fend;

    assign sof_rise = s0_q & ~s1_q;
    assign slot     = sof_rise && (ival_q == 16'd0);
    assign start    = (state_q == S_WAIT) && ENABLE_I && slot && FIFO_EMPTY_I;
    assign skip     = (state_q == S_WAIT) && ENABLE_I && slot && !FIFO_EMPTY_I;
    // FRAME_END_I beats a coincident slot, so such a slot is never counted late
    assign late     = (state_q == S_STREAM) && slot && !FRAME_END_I;
    assign fend     = ((state_q == S_STREAM) && FRAME_END_I) ||
                      ((state_q == S_DRAIN) && (PKT_DONE_I || FRAME_END_I));

    always_comb begin
        state_d  = (state_q == S_IDLE)   ? (ENABLE_I ? S_WAIT : S_IDLE) :
                   (state_q == S_WAIT)   ? (!ENABLE_I ? S_IDLE : start ? S_STREAM : S_WAIT) :
                   (state_q == S_STREAM) ? (FRAME_END_I ? S_WAIT : !ENABLE_I ? S_DRAIN : S_STREAM) :
                                           (fend ? S_IDLE : S_DRAIN);
        ival_d   = (state_q == S_IDLE) ? 16'd0 :
                   !sof_rise ? ival_q :
                   (ival_q == 16'(FRAME_INTERVAL - 1)) ? 16'd0 : ival_q + 16'd1;
        // reload on SOF wins over a coincident done pulse
        budget_d = sof_rise ? 2'(PKTS_PER_UFRAME) :
                   (PKT_DONE_I && budget_q != 2'd0) ? budget_q - 2'd1 : budget_q;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= S_IDLE;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            ival_q      <= 16'd0;
            budget_q    <= 2'd0;
            pts_q       <= 32'd0;
            uframe_q    <= 3'd0;
            sof_count_q <= 11'd0;
            start_q     <= 1'b0;
            active_q    <= 1'b0;
            fid_q       <= 1'b0;
            pts_lat_q   <= 32'd0;
            late_q      <= 8'd0;
            skip_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            s0_q        <= SOF_I;
            s1_q        <= s0_q;
            ival_q      <= ival_d;
            budget_q    <= budget_d;
            pts_q       <= pts_q + 32'd1;
            uframe_q    <= uframe_q + 3'(sof_rise);
            sof_count_q <= sof_count_q + 11'(sof_rise && uframe_q == 3'd7);
            start_q     <= start;
            active_q    <= start ? 1'b1 : fend ? 1'b0 : active_q;
            fid_q       <= fid_q ^ fend;
            pts_lat_q   <= start ? pts_q : pts_lat_q;
            late_q      <= late_q + 8'(late && late_q != 8'hff);
            skip_q      <= skip_q + 8'(skip && skip_q != 8'hff);
        end
    end

    assign FRAME_START_O = start_q;
    assign PKT_GRANT_O   = (state_q == S_STREAM) && (budget_q != 2'd0);
    assign ACTIVE_O      = active_q;
    assign FID_O         = fid_q;
    assign UFRAME_O      = uframe_q;
    assign SOF_COUNT_O   = sof_count_q;
    assign PTS_O         = pts_lat_q;
    assign LATE_CNT_O    = late_q;
    assign SKIP_CNT_O    = skip_q;
endmodule

// File: tb/tb_uvc_frame_sched.sv
// tb_uvc_frame_sched: scoreboard bench for uvc_frame_sched
module tb_uvc_frame_sched;
    logic        CLK_I = 1'b0, RST_I = 1'b1, SOF_I = 1'b0, ENABLE_I = 1'b0;
    logic        FIFO_EMPTY_I = 1'b0, PKT_DONE_I = 1'b0, FRAME_END_I = 1'b0;
    logic        FRAME_START_O, PKT_GRANT_O, ACTIVE_O, FID_O;
    logic [2:0]  UFRAME_O;
    logic [10:0] SOF_COUNT_O;
    logic [31:0] PTS_O;
    logic [7:0]  LATE_CNT_O, SKIP_CNT_O;
    int          errors = 0, checks = 0, nsof = 0;
    logic [31:0] cyc;
    int          exp_q[$];
    logic [10:0] base;

    uvc_frame_sched #(.FRAME_INTERVAL(4), .PKTS_PER_UFRAME(3)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .SOF_I(SOF_I), .ENABLE_I(ENABLE_I),
        .FIFO_EMPTY_I(FIFO_EMPTY_I), .PKT_DONE_I(PKT_DONE_I), .FRAME_END_I(FRAME_END_I),
        .FRAME_START_O(FRAME_START_O), .PKT_GRANT_O(PKT_GRANT_O), .ACTIVE_O(ACTIVE_O),
        .FID_O(FID_O), .UFRAME_O(UFRAME_O), .SOF_COUNT_O(SOF_COUNT_O), .PTS_O(PTS_O),
        .LATE_CNT_O(LATE_CNT_O), .SKIP_CNT_O(SKIP_CNT_O)
    );

    always #5 CLK_I = ~CLK_I;

    // reference free-running timestamp: cleared by reset, +1 per clock
    always @(posedge CLK_I or posedge RST_I)
        if (RST_I) cyc <= 32'd0;
        else cyc <= cyc + 32'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // frame starts are popped from the scoreboard as the DUT produces them
    always @(negedge CLK_I)
        if (!RST_I && FRAME_START_O) begin
            if (exp_q.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
            else begin
                chk("start_cycle", cyc, 32'(exp_q.pop_front()));
                chk("start_pts", PTS_O, cyc - 32'd1);
                chk("start_active", 32'(ACTIVE_O), 32'd1);
            end
        end

    task automatic step(input int n);
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    task automatic pulse_done();
        PKT_DONE_I = 1'b1;
        step(1);
        PKT_DONE_I = 1'b0;
    endtask

    task automatic pulse_end();
        FRAME_END_I = 1'b1;
        step(1);
        FRAME_END_I = 1'b0;
    endtask

    // one 20-clock microframe; optionally expects a start two edges after the rise
    // and checks the grant is low at edge k and high from edge k+1
    task automatic sof(input bit start, input bit g);
        if (start) exp_q.push_back(int'(cyc) + 2);
        SOF_I = 1'b1;
        nsof++;
        @(posedge CLK_I);
        @(negedge CLK_I);
        if (g) chk("grant_edge_k", 32'(PKT_GRANT_O), 32'd0);
        @(posedge CLK_I);
        @(negedge CLK_I);
        if (g) chk("grant_edge_k1", 32'(PKT_GRANT_O), 32'd1);
        step(1);
        SOF_I = 1'b0;
        step(17);
    endtask

    initial begin
        step(2);
        RST_I = 1'b0;
        chk("rst_start", 32'(FRAME_START_O), 0);
        chk("rst_grant", 32'(PKT_GRANT_O), 0);
        chk("rst_active", 32'(ACTIVE_O), 0);
        chk("rst_fid", 32'(FID_O), 0);
        chk("rst_uframe", 32'(UFRAME_O), 0);
        chk("rst_sofcnt", 32'(SOF_COUNT_O), 0);
        chk("rst_pts", PTS_O, 0);
        chk("rst_late", 32'(LATE_CNT_O), 0);
        chk("rst_skip", 32'(SKIP_CNT_O), 0);
        ENABLE_I = 1'b1;
        FIFO_EMPTY_I = 1'b1;
        step(3);
        sof(1, 1);
        chk("f1_active", 32'(ACTIVE_O), 1);
        pulse_end();
        chk("f1_end_active", 32'(ACTIVE_O), 0);
        chk("f1_end_fid", 32'(FID_O), 1);
        chk("wait_grant", 32'(PKT_GRANT_O), 0);
        repeat (3) sof(0, 0);
        sof(1, 1);
        for (int i = 1; i <= 4; i++) begin
            pulse_done();
            chk($sformatf("budget_%0d", i), 32'(PKT_GRANT_O), 32'(i < 3));
        end
        sof(0, 1);
        pulse_end();
        chk("f2_end_fid", 32'(FID_O), 0);
        repeat (2) sof(0, 0);
        sof(1, 1);
        chk("uframe_9", 32'(UFRAME_O), 32'(nsof % 8));
        chk("sofcnt_9", 32'(SOF_COUNT_O), 32'(nsof / 8));
        repeat (8) sof(0, 0);
        chk("late_2", 32'(LATE_CNT_O), 2);
        chk("late_active", 32'(ACTIVE_O), 1);
        pulse_end();
        chk("late_fid", 32'(FID_O), 1);
        chk("late_end_active", 32'(ACTIVE_O), 0);
        repeat (3) sof(0, 0);
        FIFO_EMPTY_I = 1'b0;
        sof(0, 0);
        chk("skip_1", 32'(SKIP_CNT_O), 1);
        chk("skip_active", 32'(ACTIVE_O), 0);
        FIFO_EMPTY_I = 1'b1;
        repeat (3) sof(0, 0);
        sof(1, 1);
        chk("skip_hold", 32'(SKIP_CNT_O), 1);
        ENABLE_I = 1'b0;
        step(1);
        chk("drain_grant", 32'(PKT_GRANT_O), 0);
        chk("drain_active", 32'(ACTIVE_O), 1);
        step(3);
        chk("drain_hold", 32'(ACTIVE_O), 1);
        pulse_done();
        chk("drain_end_active", 32'(ACTIVE_O), 0);
        chk("drain_end_fid", 32'(FID_O), 0);
        chk("idle_grant", 32'(PKT_GRANT_O), 0);
        base = SOF_COUNT_O;
        repeat (16) sof(0, 0);
        chk("sofcnt_adv", 32'(SOF_COUNT_O), 32'(11'(base + 11'd2)));
        chk("uframe_adv", 32'(UFRAME_O), 32'(nsof % 8));
        ENABLE_I = 1'b1;
        step(2);
        sof(1, 1);
        pulse_end();
        chk("pre_rst_fid", 32'(FID_O), 1);
        repeat (3) sof(0, 0);
        sof(1, 1);
        #2 RST_I = 1'b1;
        #1;
        chk("arst_start", 32'(FRAME_START_O), 0);
        chk("arst_grant", 32'(PKT_GRANT_O), 0);
        chk("arst_active", 32'(ACTIVE_O), 0);
        chk("arst_fid", 32'(FID_O), 0);
        chk("arst_uframe", 32'(UFRAME_O), 0);
        chk("arst_sofcnt", 32'(SOF_COUNT_O), 0);
        chk("arst_pts", PTS_O, 0);
        chk("arst_late", 32'(LATE_CNT_O), 0);
        chk("arst_skip", 32'(SKIP_CNT_O), 0);
        step(2);
        RST_I = 1'b0;
        nsof = 0;
        step(2);
        sof(1, 1);
        chk("post_rst_uframe", 32'(UFRAME_O), 1);
        chk("post_rst_active", 32'(ACTIVE_O), 1);
        pulse_end();
        chk("post_rst_fid", 32'(FID_O), 1);
        step(5);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uvc_frame_sched.md
# uvc_frame_sched

Microframe scheduler for the UVC isochronous video path. It sits between the USB SOF source and the payload packetizer. It paces frame starts to a fixed microframe interval and grants the packetizer a bounded number of payloads per microframe. It also owns the frame toggle (FID), the presentation timestamp, and the 11-bit SOF frame number that the packetizer writes into each payload header.

## Interface
Parameters:
- FRAME_INTERVAL, 104: microframes (125 µs) between frame-start slots; legal range 2..65535.
- PKTS_PER_UFRAME, 1: payload grants per microframe; legal range 1..3 (high-bandwidth iso).

Ports:
- CLK_I  in  1  single clock; every input is synchronous to it.
- RST_I  in  1  asynchronous, active-high reset.
- SOF_I  in  1  SOF level from the USB core; each rising edge marks one microframe.
- ENABLE_I  in  1  streaming enabled (alternate setting is non-zero).
- FIFO_EMPTY_I  in  1  endpoint FIFO is empty.
- PKT_DONE_I  in  1  one-cycle pulse when the packetizer finishes a payload.
- FRAME_END_I  in  1  one-cycle pulse marking the last payload of a frame.
- FRAME_START_O  out  1  one-cycle pulse that starts a frame.
- PKT_GRANT_O  out  1  packetizer may begin a payload; sampled only at payload boundaries.
- ACTIVE_O  out  1  high while a frame is in progress (drives VS).
- FID_O  out  1  UVC frame-ID bit.
- UFRAME_O  out  3  microframe index 0..7.
- SOF_COUNT_O  out  11  USB frame number.
- PTS_O  out  32  timestamp latched at frame start.
- LATE_CNT_O  out  8  saturating count of slots missed because a frame was still active.
- SKIP_CNT_O  out  8  saturating count of slots skipped because the FIFO was not empty.

## Operation
- Edge detect: two-stage register on SOF_I (s0, s1); sof_rise = s0 & ~s1.
- On every sof_rise:
  - uframe increments and wraps 7→0.
  - sof_count increments when uframe == 7 and wraps at 2047.
  - These counters run regardless of ENABLE_I.
- The pts counter is 32-bit, free-running, +1 every clock, and wraps.
- Interval counter (16-bit):
  - Forced to 0 in IDLE.
  - Otherwise counts sof_rise events 0..FRAME_INTERVAL-1, then wraps to 0.
  - A slot is a sof_rise with interval == 0.
- Budget counter (2-bit):
  - Reloaded to PKTS_PER_UFRAME on sof_rise.
  - Decremented on PKT_DONE_I, floored at 0.
  - If sof_rise and PKT_DONE_I coincide, reload wins and the done pulse is not charged.
- States:
  - IDLE:
    - Entered on reset or when ENABLE_I is low.
    - Outputs: ACTIVE_O = 0, PKT_GRANT_O = 0.
    - ENABLE_I high → WAIT.
  - WAIT:
    - Slot with FIFO_EMPTY_I = 1 → STREAM. FRAME_START_O pulses, PTS_O ← pts, ACTIVE_O ← 1.
    - Slot with FIFO_EMPTY_I = 0 → stay in WAIT; SKIP_CNT_O +1.
    - ENABLE_I low → IDLE.
  - STREAM:
    - PKT_GRANT_O = (budget != 0).
    - FRAME_END_I → WAIT. FID_O toggles and ACTIVE_O ← 0.
    - Slot while in STREAM: LATE_CNT_O +1 and no new start. The interval counter keeps running.
    - ENABLE_I low → DRAIN.
  - DRAIN:
    - PKT_GRANT_O = 0, ACTIVE_O stays 1.
    - PKT_DONE_I or FRAME_END_I → IDLE. FID_O toggles and ACTIVE_O ← 0.
- If FRAME_END_I and a slot occur in the same cycle, FRAME_END_I wins. The FSM goes to WAIT, the slot is consumed without a start, and LATE_CNT_O does not increment.
- LATE_CNT_O and SKIP_CNT_O saturate at 255 and clear only on reset.

## Timing
- Reset values:
  - All outputs 0, FSM in IDLE.
  - s0, s1, uframe, sof_count, pts, interval and budget all 0.
- All outputs are registered except PKT_GRANT_O, which is a decode of the state and budget registers.
- Start latency:
  - SOF_I first sampled high at edge k; sof_rise is seen at edge k+1.
  - FRAME_START_O, PTS_O, ACTIVE_O and UFRAME_O all update from edge k+1.
  - FRAME_START_O is high for exactly one cycle.
- Budget:
  - The budget reload is visible on PKT_GRANT_O from edge k+1.
  - A PKT_DONE_I sampled at edge n can drop PKT_GRANT_O from edge n.
- FRAME_END_I sampled at edge n: ACTIVE_O low and FID_O toggled from edge n.
- When RST_I asserts mid-frame, all outputs clear asynchronously. No FID toggle is preserved.

## Test plan
- Reset, ENABLE_I = 1, FIFO_EMPTY_I = 1, FRAME_INTERVAL = 4; SOF_I pulses every 20 clocks → FRAME_START_O on the 1st, 5th and 9th SOF, each 2 edges after SOF_I rises; PTS_O equals pts at the pulse.
- PKTS_PER_UFRAME = 3; 4 PKT_DONE_I pulses within one microframe → PKT_GRANT_O low after the 3rd pulse; high again 2 edges after the next SOF_I rise.
- FRAME_END_I withheld across 2 slots → LATE_CNT_O = 2, no extra FRAME_START_O; next FRAME_END_I toggles FID_O 0→1.
- FIFO_EMPTY_I = 0 at a slot → SKIP_CNT_O = 1, FSM stays in WAIT; start occurs at the following slot once FIFO_EMPTY_I = 1.
- ENABLE_I drops mid-frame → PKT_GRANT_O low at once, ACTIVE_O stays 1 until PKT_DONE_I, then ACTIVE_O = 0, FID_O toggled, FSM in IDLE; 16 SOF rises later SOF_COUNT_O has advanced by 2.
- RST_I asserted mid-STREAM → all outputs 0 asynchronously; after release, the first start occurs on the first slot.
